// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the memory-bus arbiter: FSM states, requester ids and the
// default address that signals end-of-test.
package mem_bus_pkg;

    localparam logic [15:0] HALT_ADDR_DEF = 16'hFF00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } arb_state_t;

    typedef enum logic {
        PORT_IF,
        PORT_DM
    } port_t;

endpackage

// File: rtl/mem_access_arbiter_rr_arb2.sv
// Two-way round-robin picker. req[0] is instruction fetch, req[1] is data.
// A lone request always wins; on a tie the port that did not win last time
// gets the grant. The last-grant register itself lives in the caller.
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic  [1:0] req,
    input  port_t       last_grant,
    output logic        grant_valid,
    output port_t       grant
);

    // Pick the winner from the current requests and the previous grant.
    always_comb begin
        grant_valid = |req;
        grant       = PORT_IF;
        case (req)
            2'b01:   grant = PORT_IF;
            2'b10:   grant = PORT_DM;
            2'b11:   grant = (last_grant == PORT_DM) ? PORT_IF : PORT_DM;
            default: grant = PORT_IF;
        endcase
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Serialises instruction-fetch and data requests onto one 16-bit memory port.
// Each access takes IDLE -> ACCESS -> RESP, so the port sustains one access
// every three cycles. A data write to HALT_ADDR freezes all further grants
// until reset.
//
// Handshake: a requester raises req with stable address/we/wdata and holds it
// until it sees its ack. The ack is a one-cycle pulse in the RESP cycle, and
// read data is valid in that same cycle and held afterwards. Requests are not
// sampled in RESP; a req still high when the FSM returns to IDLE is a new
// request.
module mem_access_arbiter
    import mem_bus_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] HALT_ADDR = HALT_ADDR_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_address,
    output logic              o_if_ack,
    output logic [DATA_W-1:0] o_if_data,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_address,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_ack,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_mem_wr,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_busy,
    output logic              o_halted
);

    arb_state_t        state_q,      state_d;
    port_t             last_grant_q, last_grant_d;
    port_t             winner_q,     winner_d;
    logic              we_q,         we_d;
    logic              if_ack_q,     if_ack_d;
    logic              dm_ack_q,     dm_ack_d;
    logic [DATA_W-1:0] if_data_q,    if_data_d;
    logic [DATA_W-1:0] dm_rdata_q,   dm_rdata_d;
    logic              mem_wr_q,     mem_wr_d;
    logic              mem_rd_q,     mem_rd_d;
    logic [ADDR_W-1:0] address_q,    address_d;
    logic [DATA_W-1:0] data_q,       data_d;
    logic              halted_q,     halted_d;

    logic              grant_valid;
    port_t             grant;

    rr_arb2 u_rr_arb2 (
        .req         ({i_dm_req, i_if_req}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_DM;
            winner_q     <= PORT_IF;
            we_q         <= 1'b0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_data_q    <= '0;
            dm_rdata_q   <= '0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            address_q    <= '0;
            data_q       <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_data_q    <= if_data_d;
            dm_rdata_q   <= dm_rdata_d;
            mem_wr_q     <= mem_wr_d;
            mem_rd_q     <= mem_rd_d;
            address_q    <= address_d;
            data_q       <= data_d;
            halted_q     <= halted_d;
        end
    end

    // Next-state logic: grant in IDLE, strobe in ACCESS, ack in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        we_d         = we_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_data_d    = if_data_q;
        dm_rdata_d   = dm_rdata_q;
        mem_wr_d     = 1'b0;
        mem_rd_d     = 1'b0;
        address_d    = address_q;
        data_d       = data_q;
        halted_d     = halted_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid && !halted_q) begin
                    winner_d     = grant;
                    last_grant_d = grant;
                    state_d      = ST_ACCESS;
                    if (grant == PORT_IF) begin
                        address_d = i_if_address;
                        we_d      = 1'b0;
                        mem_rd_d  = 1'b1;
                    end else begin
                        address_d = i_dm_address;
                        we_d      = i_dm_we;
                        mem_wr_d  = i_dm_we;
                        mem_rd_d  = !i_dm_we;
                        if (i_dm_we) begin
                            data_d = i_dm_wdata;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (winner_q == PORT_IF) begin
                    if_ack_d  = 1'b1;
                    if_data_d = i_data;
                end else begin
                    dm_ack_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = i_data;
                    end else if (address_q == HALT_ADDR) begin
                        halted_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_if_ack   = if_ack_q;
    assign o_if_data  = if_data_q;
    assign o_dm_ack   = dm_ack_q;
    assign o_dm_rdata = dm_rdata_q;
    assign o_mem_wr   = mem_wr_q;
    assign o_mem_rd   = mem_rd_q;
    assign o_address  = address_q;
    assign o_data     = data_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_halted   = halted_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural memory. Stimulus
// pushes expected acks/data/writes into queues; a negedge monitor pops and
// compares whenever the DUT presents an ack or a memory strobe.
module tb_mem_access_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic        i_if_req;
    logic [15:0] i_if_address;
    logic        o_if_ack;
    logic [15:0] o_if_data;
    logic        i_dm_req;
    logic        i_dm_we;
    logic [15:0] i_dm_address;
    logic [15:0] i_dm_wdata;
    logic        o_dm_ack;
    logic [15:0] o_dm_rdata;
    logic        o_mem_wr;
    logic        o_mem_rd;
    logic [15:0] o_address;
    logic [15:0] o_data;
    logic [15:0] i_data;
    logic        o_busy;
    logic        o_halted;

    int total = 0;
    int bad   = 0;

    // Expected order of acks (0 = IF, 1 = DM), per-port data, and writes.
    logic [0:0]  ord_exp_q[$];
    logic [15:0] if_exp_q[$];
    logic [15:0] dm_exp_q[$];
    logic [31:0] wr_exp_q[$];

    logic [15:0] mem [0:65535];

    mem_access_arbiter dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_if_req     (i_if_req),
        .i_if_address (i_if_address),
        .o_if_ack     (o_if_ack),
        .o_if_data    (o_if_data),
        .i_dm_req     (i_dm_req),
        .i_dm_we      (i_dm_we),
        .i_dm_address (i_dm_address),
        .i_dm_wdata   (i_dm_wdata),
        .o_dm_ack     (o_dm_ack),
        .o_dm_rdata   (o_dm_rdata),
        .o_mem_wr     (o_mem_wr),
        .o_mem_rd     (o_mem_rd),
        .o_address    (o_address),
        .o_data       (o_data),
        .i_data       (i_data),
        .o_busy       (o_busy),
        .o_halted     (o_halted)
    );

    // ---------------- clock / reset / memory model ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    assign i_data = mem[o_address];

    always @(posedge i_clk) begin
        if (o_mem_wr) mem[o_address] <= o_data;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic if_access(input logic [15:0] a, output int lat);
        i_if_req     = 1'b1;
        i_if_address = a;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!o_if_ack && lat < 20);
        check("if_ack_timeout", {31'd0, o_if_ack}, 32'd1);
        i_if_req = 1'b0;
    endtask

    task automatic dm_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                             output int lat);
        i_dm_req     = 1'b1;
        i_dm_we      = we;
        i_dm_address = a;
        i_dm_wdata   = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!o_dm_ack && lat < 20);
        check("dm_ack_timeout", {31'd0, o_dm_ack}, 32'd1);
        i_dm_req = 1'b0;
        i_dm_we  = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic prev_ack    = 1'b0;
    logic prev_strobe = 1'b0;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_mem_wr || o_mem_rd) begin
                check("strobe_excl",  {31'd0, o_mem_wr & o_mem_rd}, 32'd0);
                check("strobe_width", {31'd0, prev_strobe}, 32'd0);
            end
            if (o_mem_wr) begin
                if (wr_exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mem_wr_unexpected: got addr=%h data=%h want none", o_address, o_data);
                end else begin
                    check("mem_write", {o_address, o_data}, wr_exp_q.pop_front());
                end
            end
            if (o_if_ack || o_dm_ack) begin
                check("ack_excl",  {31'd0, o_if_ack & o_dm_ack}, 32'd0);
                check("ack_width", {31'd0, prev_ack}, 32'd0);
                if (ord_exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ack_unexpected: got if=%b dm=%b want none", o_if_ack, o_dm_ack);
                end else begin
                    check("ack_order", {31'd0, o_dm_ack}, {31'd0, ord_exp_q.pop_front()});
                end
            end
            if (o_if_ack && if_exp_q.size() != 0)
                check("if_data", {16'd0, o_if_data}, {16'd0, if_exp_q.pop_front()});
            if (o_dm_ack && dm_exp_q.size() != 0)
                check("dm_rdata", {16'd0, o_dm_rdata}, {16'd0, dm_exp_q.pop_front()});
        end
        prev_ack    = o_if_ack | o_dm_ack;
        prev_strobe = o_mem_wr | o_mem_rd;
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int lat;
        int acks;
        int cyc;
        int last_ack;

        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0010] = 16'h1234;
        mem[16'h0030] = 16'hA5A5;
        for (int i = 0; i < 10; i++) mem[16'h0040 + i] = 16'h1000 + 16'(i);

        i_rst = 1'b1; i_if_req = 1'b0; i_if_address = '0;
        i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_address = '0; i_dm_wdata = '0;
        tick(); tick();
        check("reset_outputs",
              {o_if_ack, o_dm_ack, o_mem_wr, o_mem_rd, o_busy, o_halted,
               |o_address, |o_data, |o_if_data, |o_dm_rdata}, 32'd0);
        i_rst = 1'b0;
        tick();

        // 1: single IF read after reset
        ord_exp_q.push_back(1'b0); if_exp_q.push_back(16'h1234);
        i_if_req = 1'b1; i_if_address = 16'h0010;
        tick();
        check("t1_mem_rd",  {31'd0, o_mem_rd}, 32'd1);
        check("t1_address", {16'd0, o_address}, 32'h0010);
        check("t1_busy",    {31'd0, o_busy}, 32'd1);
        tick();
        check("t1_ack",     {31'd0, o_if_ack}, 32'd1);
        i_if_req = 1'b0;
        tick(); tick();

        // 2: DM write then read back
        ord_exp_q.push_back(1'b1); dm_exp_q.push_back(16'h0000);
        wr_exp_q.push_back({16'h0020, 16'hBEEF});
        dm_access(1'b1, 16'h0020, 16'hBEEF, lat);
        check("t2_wr_latency", lat, 2);
        ord_exp_q.push_back(1'b1); dm_exp_q.push_back(16'hBEEF);
        dm_access(1'b0, 16'h0020, 16'h0000, lat);
        check("t2_rd_latency", lat, 3);
        tick(); tick();

        // 3: both requesters held after reset -> IF, DM, IF, DM
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        ord_exp_q.push_back(1'b0); ord_exp_q.push_back(1'b1);
        ord_exp_q.push_back(1'b0); ord_exp_q.push_back(1'b1);
        if_exp_q.push_back(16'h1234); if_exp_q.push_back(16'h1234);
        dm_exp_q.push_back(16'hBEEF); dm_exp_q.push_back(16'hBEEF);
        i_if_req = 1'b1; i_if_address = 16'h0010;
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_address = 16'h0020;
        acks = 0; cyc = 0;
        while (acks < 4 && cyc < 40) begin
            tick(); cyc++;
            if (o_if_ack || o_dm_ack) acks++;
        end
        i_if_req = 1'b0; i_dm_req = 1'b0;
        check("t3_acks",   acks, 4);
        check("t3_cycles", cyc, 11);
        tick(); tick();

        // 4: DM write to halt address, then IF is starved until reset
        ord_exp_q.push_back(1'b1); dm_exp_q.push_back(16'hBEEF);
        wr_exp_q.push_back({16'hFF00, 16'h0055});
        dm_access(1'b1, 16'hFF00, 16'h0055, lat);
        check("t4_halted", {31'd0, o_halted}, 32'd1);
        i_if_req = 1'b1; i_if_address = 16'h0010;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_if_ack) acks++;
        end
        check("t4_no_ack",  acks, 0);
        check("t4_idle",    {31'd0, o_busy}, 32'd0);
        check("t4_halt_mem", {16'd0, mem[16'hFF00]}, 32'h0055);
        i_rst = 1'b1; tick();
        check("t4_unhalt",  {31'd0, o_halted}, 32'd0);
        i_if_req = 1'b0; i_rst = 1'b0;
        tick();

        // 5: reset during ACCESS of a DM read abandons it
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_address = 16'h0030;
        tick();
        check("t5_mem_rd", {31'd0, o_mem_rd}, 32'd1);
        i_rst = 1'b1; i_dm_req = 1'b0;
        tick();
        check("t5_cleared",
              {o_if_ack, o_dm_ack, o_mem_wr, o_mem_rd, o_busy, o_halted,
               |o_address, |o_data, |o_if_data, |o_dm_rdata}, 32'd0);
        tick();
        check("t5_no_ack", {31'd0, o_dm_ack}, 32'd0);
        i_rst = 1'b0;
        tick();
        ord_exp_q.push_back(1'b1); dm_exp_q.push_back(16'hA5A5);
        dm_access(1'b0, 16'h0030, 16'h0000, lat);
        check("t5_latency", lat, 2);
        tick(); tick();

        // 6: IF held for 10 accesses, one ack every third cycle
        for (int i = 0; i < 10; i++) begin
            ord_exp_q.push_back(1'b0);
            if_exp_q.push_back(16'h1000 + 16'(i));
        end
        i_if_req = 1'b1; i_if_address = 16'h0040;
        acks = 0; cyc = 0; last_ack = 0;
        while (acks < 10 && cyc < 60) begin
            tick(); cyc++;
            if (o_if_ack) begin
                if (acks == 0) check("t6_first_latency", cyc, 2);
                else           check("t6_ack_gap", cyc - last_ack, 3);
                last_ack = cyc;
                acks++;
                i_if_address = 16'h0040 + 16'(acks);
                if (acks == 10) i_if_req = 1'b0;
            end
        end
        i_if_req = 1'b0;
        check("t6_acks", acks, 10);
        tick(); tick(); tick();

        check("queues_drained",
              ord_exp_q.size() + if_exp_q.size() + dm_exp_q.size() + wr_exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
